// File: rtl/cikis_paketleyici_if.sv
// rtl/cikis_paketleyici_if.sv - upstream word and downstream byte handshake bundle
interface cikis_paketleyici_if;
   logic        etkin_i;
   logic [23:0] pixel_i;
   logic        stal_o;
   logic [7:0]  veri_o;
   logic        gecerli_o;
   logic        hazir_i;

   modport slave (
      input  etkin_i,
      input  pixel_i,
      input  hazir_i,
      output stal_o,
      output veri_o,
      output gecerli_o
   );

   modport master (
      output etkin_i,
      output pixel_i,
      output hazir_i,
      input  stal_o,
      input  veri_o,
      input  gecerli_o
   );
endinterface

// File: rtl/cikis_paketleyici.sv
// rtl/cikis_paketleyici.sv - result word buffer and MSB-first byte serialiser
module cikis_paketleyici #(
   parameter int DERINLIK = 8,
   parameter int SAYAC_W  = 17
) (
   input  logic               clk_i,
   input  logic               rstn_i,
   input  logic               basla_i,
   input  logic [1:0]         bayt_sayisi_i,
   input  logic [SAYAC_W-1:0] beklenen_i,
   cikis_paketleyici_if.slave bus,
   output logic               bitti_o
);
   localparam int AW = $clog2(DERINLIK);
   localparam logic [AW-1:0]      PTR_BIR   = AW'(1);
   localparam logic [AW:0]        SAYI_BIR  = (AW+1)'(1);
   localparam logic [AW:0]        ESIK      = (AW+1)'(DERINLIK - 1);
   localparam logic [AW:0]        DOLU      = (AW+1)'(DERINLIK);
   localparam logic [SAYAC_W-1:0] SAYAC_BIR = SAYAC_W'(1);

   typedef enum logic {BOSTA, CALIS} durum_t;

   durum_t             durum;
   logic [23:0]        mem [DERINLIK];
   logic [AW-1:0]      yaz_ptr;
   logic [AW-1:0]      oku_ptr;
   logic [AW:0]        doluluk;
   logic [1:0]         bs_r;
   logic [SAYAC_W-1:0] bek_r;
   logic [SAYAC_W-1:0] kabul_sayac;
   logic [SAYAC_W-1:0] cikan_sayac;
   logic [23:0]        bas_kelime;
   logic [1:0]         k_r;
   logic [23:0]        fifo_bas;
   logic               it;
   logic               cek;
   logic               aktarim;
   logic               son_aktarim;
   logic               is_bitti;

   function automatic logic [7:0] bayt_sec(input logic [23:0] w, input logic [1:0] k);
      case (k)
         2'd2:    bayt_sec = w[23:16];
         2'd1:    bayt_sec = w[15:8];
         default: bayt_sec = w[7:0];
      endcase
   endfunction

   // One word of slack: the word taken on the edge where stal rises still has a slot.
   assign bus.stal_o  = (durum == CALIS) && (doluluk >= ESIK);
   assign fifo_bas    = mem[oku_ptr];
   assign aktarim     = bus.gecerli_o && bus.hazir_i;
   assign son_aktarim = aktarim && (k_r == 2'd0);
   assign is_bitti    = son_aktarim && ((cikan_sayac + SAYAC_BIR) == bek_r);
   // Words past the job length are still consumed upstream but never stored.
   assign it  = (durum == CALIS) && !basla_i && bus.etkin_i && !bus.stal_o
                && (kabul_sayac != bek_r);
   // Load the serialiser when idle or on the last byte edge so words run back to back.
   assign cek = (durum == CALIS) && !basla_i && (doluluk != '0)
                && (!bus.gecerli_o || son_aktarim) && !is_bitti;

   // FIFO storage, written only on accepted words.
   always_ff @(posedge clk_i) begin
      if (it) begin
         mem[yaz_ptr] <= bus.pixel_i;
      end
   end

   // Job control, FIFO pointers, serialiser and counters.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         durum         <= BOSTA;
         yaz_ptr       <= '0;
         oku_ptr       <= '0;
         doluluk       <= '0;
         bs_r          <= 2'd1;
         bek_r         <= '0;
         kabul_sayac   <= '0;
         cikan_sayac   <= '0;
         bas_kelime    <= '0;
         k_r           <= '0;
         bus.veri_o    <= '0;
         bus.gecerli_o <= 1'b0;
         bitti_o       <= 1'b0;
      end else begin
         bitti_o <= 1'b0;
         if (basla_i) begin
            bs_r          <= (bayt_sayisi_i == 2'd0) ? 2'd1 : bayt_sayisi_i;
            bek_r         <= beklenen_i;
            yaz_ptr       <= '0;
            oku_ptr       <= '0;
            doluluk       <= '0;
            kabul_sayac   <= '0;
            cikan_sayac   <= '0;
            k_r           <= '0;
            bus.gecerli_o <= 1'b0;
            if (beklenen_i == '0) begin
               bitti_o <= 1'b1;
               durum   <= BOSTA;
            end else begin
               durum   <= CALIS;
            end
         end else if (durum == CALIS) begin
            if (it) begin
               yaz_ptr     <= yaz_ptr + PTR_BIR;
               kabul_sayac <= kabul_sayac + SAYAC_BIR;
            end
            if (cek) begin
               oku_ptr <= oku_ptr + PTR_BIR;
            end
            if (it && !cek) begin
               doluluk <= doluluk + SAYI_BIR;
            end else if (cek && !it) begin
               doluluk <= doluluk - SAYI_BIR;
            end
            if (cek) begin
               bas_kelime    <= fifo_bas;
               k_r           <= bs_r - 2'd1;
               bus.veri_o    <= bayt_sec(fifo_bas, bs_r - 2'd1);
               bus.gecerli_o <= 1'b1;
            end else if (aktarim) begin
               if (k_r != 2'd0) begin
                  k_r        <= k_r - 2'd1;
                  bus.veri_o <= bayt_sec(bas_kelime, k_r - 2'd1);
               end else begin
                  bus.gecerli_o <= 1'b0;
               end
            end
            if (son_aktarim) begin
               cikan_sayac <= cikan_sayac + SAYAC_BIR;
            end
            if (is_bitti) begin
               bitti_o <= 1'b1;
               durum   <= BOSTA;
            end
         end
      end
   end

   // The stal threshold leaves a free slot, so a push into a full FIFO is a design error.
   a_dolu_yazma : assert property (@(posedge clk_i) disable iff (!rstn_i) it |-> (doluluk != DOLU));

endmodule

// File: doc/cikis_paketleyici.md
Name: cikis_paketleyici

Overview:
- Sits directly downstream of gorev_birimi and consumes its 24-bit result stream (pixel_o/etkin_o).
- Buffers accepted result words in a small FIFO and drives gorev_birimi's stal_i from its fill level.
- Serialises each word into 1–3 bytes, most significant byte first, on a valid/ready byte stream toward the UART/DMA egress.
- Counts emitted words against a per-job expected count and pulses bitti_o when the job completes.

Parameters:
- DERINLIK, 8, FIFO depth in 24-bit words; power of two, ≥2.
- SAYAC_W, 17, width of the word counters; covers 320*240 = 76800.

Ports:
- clk_i  input  1  clock; single clock domain.
- rstn_i  input  1  asynchronous, active-low reset.
- basla_i  input  1  one-cycle job start; latches the job configuration.
- bayt_sayisi_i  input  2  bytes per word: 1 = gray (pixel_o[7:0]), 2 = 16-bit, 3 = RGB/histogram count; 0 is treated as 1.
- beklenen_i  input  SAYAC_W  number of words in the job (256 for GRV4_H, 76800 for image tasks).
- etkin_i  input  1  upstream word valid (connects to gorev_birimi etkin_o).
- pixel_i  input  24  upstream word (connects to gorev_birimi pixel_o).
- stal_o  output  1  backpressure to upstream (connects to gorev_birimi stal_i).
- veri_o  output  8  output byte.
- gecerli_o  output  1  output byte valid.
- hazir_i  input  1  downstream ready.
- bitti_o  output  1  one-cycle job-complete pulse.

Behaviour:
- Reset values: all outputs 0; FIFO empty; state BOSTA; all counters 0.
- States:
  - BOSTA: basla_i → CALIS. Latch bayt_sayisi_i and beklenen_i, clear FIFO, byte index and counters. In BOSTA, etkin_i is ignored, stal_o = 0 and gecerli_o = 0.
  - CALIS: runs the job. basla_i in CALIS restarts: flush the FIFO, drop the byte in flight (gecerli_o = 0 next cycle), relatch the configuration, stay in CALIS.
  - Done: when the last byte of word number beklenen is transferred, pulse bitti_o for exactly one cycle in that same transfer cycle's next edge, then return to BOSTA.
- Input acceptance:
  - A word is accepted on a rising edge with etkin_i = 1, stal_o = 0 and state CALIS.
  - This matches the upstream rule that a word is consumed when etkin && !stal.
  - Words beyond beklenen accepted-count are dropped; the accepted-counter saturates at beklenen.
- stal_o:
  - stal_o = 1 when FIFO occupancy ≥ DERINLIK-1; otherwise 0.
  - It is a function of registered state only, with no combinational path from etkin_i or hazir_i.
  - With one-deep slack, a word accepted on the edge stal_o rises still fits.
- FIFO behaviour:
  - Simultaneous push and pop in one cycle leaves occupancy unchanged.
  - Pointers wrap modulo DERINLIK.
  - Push when full never occurs by construction. An assertion flags it.
- Serialiser: holds the head word and a byte index k, counting down from bayt_sayisi-1 to 0.
  - veri_o = head[8k+7:8k], registered.
  - gecerli_o rises the cycle after the FIFO becomes non-empty (minimum latency of 2 cycles from accept to first gecerli_o).
  - A transfer happens on an edge with gecerli_o && hazir_i.
  - While hazir_i = 0, veri_o and gecerli_o hold stable.
  - After the last byte, pop the word and present the next word's first byte in the following cycle if one is available. Back-to-back output at 1 byte/cycle is required.
- Counters:
  - The emitted-word counter increments on the last byte transfer.
  - It compares against the latched beklenen.
  - A beklenen of 0 completes immediately: bitti_o pulses the cycle after basla_i.
- Asynchronous reset mid-job returns everything to reset values immediately; no byte is emitted after reset asserts.

Test Plan:
- Gray mode: basla_i with bayt_sayisi = 1 and beklenen = 4; words 0x000011, 0x000022, 0x000033, 0x000044 with hazir_i = 1 → bytes 11, 22, 33, 44 in order. bitti_o pulses once after byte 44; state BOSTA.
- Histogram mode: bayt_sayisi = 3, beklenen = 2; words 0x0A0B0C, 0x000100 → bytes 0A, 0B, 0C, 00, 01, 00 on consecutive cycles; bitti_o pulses once.
- Backpressure: DERINLIK = 8, bayt_sayisi = 3, hazir_i = 0, etkin_i held high → stal_o rises once 7 words are buffered. Exactly 8 words are accepted; no loss. Release hazir_i → all 24 bytes emerge in order.
- Output stall: hold hazir_i = 0 for 5 cycles mid-word → veri_o and gecerli_o stay unchanged; no byte is duplicated or skipped.
- Restart and excess input:
  - basla_i mid-job (2 of 4 words sent), then a new job with beklenen = 1 and word 0x0000AB → only byte AB follows; one bitti_o.
  - Feeding 3 words to a beklenen = 2 job → third word dropped.
- Full image: run the gorev_birimi GRV5_HE stream (320x240, stall every 2nd pixel) through the block with bayt_sayisi = 3 → 230400 bytes matching sonuc.txt; bitti_o pulses exactly once.
